// File: rtl/dram_loader.sv
// Diagnostic DRAM loader: streams write-range or verify-range commands into the
// 512-word IR dispatch RAM, inserting odd parity on writes and checking it on reads.
module dram_loader #(
    parameter int  DRAM_SIZE  = 512,
    parameter int  DRAM_WIDTH = 15,
    localparam int AW         = $clog2(DRAM_SIZE),
    localparam int CW         = $clog2(DRAM_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [AW-1:0]         baseAddr,
    input  logic [CW-1:0]         count,
    input  logic                  abort,
    input  logic [DRAM_WIDTH-1:0] wdata,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [AW-1:0]         dramAddr,
    output logic [DRAM_WIDTH-1:0] dramDin,
    output logic                  dramWe,
    input  logic [DRAM_WIDTH-1:0] dramDout,
    output logic                  dramOwn,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  parErr,
    output logic [AW-1:0]         errAddr
);
    // Word bits are numbered [0:14] from the MSB, so PAR (bit 6) sits at vector index 8.
    localparam int PAR_BIT = DRAM_WIDTH - 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAITD,
        S_WRITE,
        S_READ,
        S_CMP,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_mode;
    logic [AW-1:0]         r_addr;
    logic [CW-1:0]         r_remain;
    logic [DRAM_WIDTH-1:0] r_word;
    logic                  r_error;
    logic                  r_par_err;
    logic [AW-1:0]         r_err_addr;

    logic                  w_start;
    logic                  w_capture;
    logic                  w_advance;
    logic                  w_par_fail;
    logic                  w_mismatch;
    logic                  w_fail;
    logic                  w_last;
    logic                  w_busy;
    logic [AW-1:0]         w_addr_inc;

    function automatic logic [DRAM_WIDTH-1:0] f_add_parity(input logic [DRAM_WIDTH-1:0] i_word);
        logic [DRAM_WIDTH-1:0] v_word;
        v_word          = i_word;
        v_word[PAR_BIT] = 1'b0;
        v_word[PAR_BIT] = ~^v_word;
        return v_word;
    endfunction

    assign w_start    = (r_state == S_IDLE) & start;
    assign w_capture  = (r_state == S_WAITD) & wvalid & ~abort;
    assign w_par_fail = ~^dramDout;
    assign w_mismatch = (dramDout != r_word);
    assign w_fail     = w_par_fail | w_mismatch;
    assign w_last     = (r_remain == CW'(1));
    assign w_advance  = ~abort & ((r_state == S_WRITE) | ((r_state == S_CMP) & ~w_fail));
    assign w_addr_inc = (r_addr == AW'(DRAM_SIZE - 1)) ? '0 : r_addr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (count == '0) ? S_DONE : S_WAITD;
                end
            end
            S_WAITD: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (wvalid) begin
                    w_state_next = r_mode ? S_READ : S_WRITE;
                end
            end
            S_WRITE: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = w_last ? S_DONE : S_WAITD;
                end
            end
            S_READ: begin
                w_state_next = abort ? S_IDLE : S_CMP;
            end
            S_CMP: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_fail || w_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_WAITD;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= 1'b0;
            r_addr     <= '0;
            r_remain   <= '0;
            r_word     <= '0;
            r_error    <= 1'b0;
            r_par_err  <= 1'b0;
            r_err_addr <= '0;
        end else begin
            if (w_start) begin
                r_error    <= 1'b0;
                r_par_err  <= 1'b0;
                r_err_addr <= '0;
                if (count != '0) begin
                    r_mode   <= mode;
                    r_addr   <= baseAddr;
                    r_remain <= count;
                end
            end
            if (w_capture) begin
                r_word <= f_add_parity(wdata);
            end
            if (w_advance) begin
                r_addr   <= w_addr_inc;
                r_remain <= r_remain - 1'b1;
            end
            // Parity is reported in preference to a data mismatch on the same word.
            if ((r_state == S_CMP) && !abort && w_fail) begin
                r_error    <= 1'b1;
                r_par_err  <= w_par_fail;
                r_err_addr <= r_addr;
            end
        end
    end

    assign w_busy   = (r_state != S_IDLE) && (r_state != S_DONE);
    assign busy     = w_busy;
    assign dramOwn  = w_busy;
    assign wready   = (r_state == S_WAITD);
    assign dramWe   = (r_state == S_WRITE);
    assign done     = (r_state == S_DONE);
    assign dramAddr = r_addr;
    assign dramDin  = r_word;
    assign error    = r_error;
    assign parErr   = r_par_err;
    assign errAddr  = r_err_addr;

endmodule

// File: tb/tb_dram_loader.sv
// Self-checking bench for dram_loader: command table plus hand-written reset/abort
// sequences, with a behavioural DRAM and a write scoreboard.
module tb_dram_loader;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [8:0]  baseAddr;
    logic [9:0]  count;
    logic        abort;
    logic [14:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [8:0]  dramAddr;
    logic [14:0] dramDin;
    logic        dramWe;
    logic [14:0] dramDout;
    logic        dramOwn;
    logic        busy;
    logic        done;
    logic        error;
    logic        parErr;
    logic [8:0]  errAddr;

    dram_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .baseAddr (baseAddr),
        .count    (count),
        .abort    (abort),
        .wdata    (wdata),
        .wvalid   (wvalid),
        .wready   (wready),
        .dramAddr (dramAddr),
        .dramDin  (dramDin),
        .dramWe   (dramWe),
        .dramDout (dramDout),
        .dramOwn  (dramOwn),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .parErr   (parErr),
        .errAddr  (errAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Word with bit 6 (index 8) chosen so the XOR of all 15 bits is 1.
    function automatic logic [14:0] with_par(input logic [14:0] d);
        logic [14:0] t;
        t = d & ~15'h0100;
        return (^t) ? t : (t | 15'h0100);
    endfunction

    // Behavioural DRAM: registered read, optional corruption for verify tests.
    logic [14:0] mem  [512];
    logic [14:0] good [512];
    logic        ld_req;
    logic [1:0]  fault;
    logic [8:0]  faddr;

    always @(posedge clk) begin
        if (ld_req) begin
            for (int a = 0; a < 512; a++) mem[a] <= good[a];
            if (fault[0]) mem[faddr] <= good[faddr] ^ 15'h0005;
        end else if (dramWe) begin
            mem[dramAddr] <= dramDin;
        end
        dramDout <= mem[dramAddr] ^ ((fault[1] && dramAddr == faddr) ? 15'h0001 : 15'h0000);
    end

    typedef struct packed {
        logic [8:0]  addr;
        logic [14:0] data;
    } wr_t;
    wr_t sb[$];

    always @(negedge clk) begin
        if (rst_n && dramWe) begin
            check("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", dramAddr, e.addr);
                check("wr_data", dramDin, e.data);
            end
        end
    end

    typedef struct {
        bit          mode;
        logic [8:0]  base;
        logic [9:0]  cnt;
        logic [14:0] dbase;
        bit          stall;
        bit          busy_start;
        logic [1:0]  fault;
        logic [8:0]  faddr;
        int          rst_w;
        int          exp_lat;
        bit          exp_err;
        bit          exp_par;
        logic [8:0]  exp_eaddr;
        int          exp_beats;
    } vec_t;

    vec_t tbl [10];

    task automatic run_cmd(input vec_t v);
        int          lat;
        int          beats;
        int          nw;
        int          bad;
        bit          got_done;
        logic [8:0]  a;
        logic [14:0] d;
        fault  = v.fault;
        faddr  = v.faddr;
        ld_req = 1'b1;
        @(negedge clk);
        ld_req   = 1'b0;
        start    = 1'b1;
        mode     = v.mode;
        baseAddr = v.base;
        count    = v.cnt;
        wvalid   = 1'b0;
        @(negedge clk);
        start    = 1'b0;
        lat      = 1;
        beats    = 0;
        nw       = 0;
        got_done = 1'b0;
        while (lat <= 3000) begin
            if (dramWe) nw++;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (v.rst_w != 0 && nw == v.rst_w) begin
                #2 rst_n = 1'b0;
                #1 check("rst_async_outputs",
                         {wready, dramWe, dramOwn, busy, done, error, parErr, dramAddr, dramDin, errAddr}, 0);
                sb.delete();
                wvalid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check("rst_release_idle", {busy, wready, done, dramWe}, 0);
                $display("cmd reset: base=%0h cnt=%0d reset during write %0d", v.base, v.cnt, nw);
                return;
            end
            if (v.busy_start && lat == 3) begin
                start    = 1'b1;
                mode     = ~v.mode;
                count    = 10'd0;
                baseAddr = 9'd0;
            end else begin
                start    = 1'b0;
                mode     = v.mode;
                count    = v.cnt;
                baseAddr = v.base;
            end
            wvalid = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            a      = v.base + 9'(beats);
            d      = v.mode ? good[a] : (v.dbase + 15'(beats));
            wdata  = d ^ (beats[0] ? 15'h0100 : 15'h0000);
            if (wready && wvalid) begin
                if (!v.mode) sb.push_back('{addr: a, data: with_par(d)});
                beats++;
            end
            @(negedge clk);
            lat++;
        end
        wvalid = 1'b0;
        start  = 1'b0;
        check("done_seen", got_done, 1);
        if (got_done) begin
            if (v.exp_lat >= 0) check("latency", lat, v.exp_lat);
            check("error", error, v.exp_err);
            check("parErr", parErr, v.exp_par);
            check("errAddr", errAddr, v.exp_eaddr);
            check("beats", beats, v.exp_beats);
            check("writes", nw, v.mode ? 0 : int'(v.cnt));
            check("sb_empty", sb.size(), 0);
            if (!v.mode && v.cnt != 0) begin
                bad = 0;
                for (int k = 0; k < int'(v.cnt); k++) begin
                    a = v.base + 9'(k);
                    if (mem[a] !== with_par(v.dbase + 15'(k))) bad++;
                end
                check("mem_range", bad, 0);
            end
        end
        $display("cmd mode=%0d base=%0h cnt=%0d lat=%0d beats=%0d writes=%0d err=%0d par=%0d eaddr=%0h",
                 v.mode, v.base, v.cnt, lat, beats, nw, error, parErr, errAddr);
        @(negedge clk);
        check("idle_after_done", {busy, done, dramOwn}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t rv;
        bit   seen;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; baseAddr = '0; count = '0;
        abort = 1'b0; wdata = '0; wvalid = 1'b0; ld_req = 1'b0; fault = '0; faddr = '0;
        for (int a = 0; a < 512; a++) good[a] = with_par(15'($urandom));

        //            mode base     cnt      dbase     stl bsy flt    faddr    rst lat   err par eaddr    beats
        tbl[0] = '{1'b0, 9'd510, 10'd4,   15'h0001, 1'b0, 1'b0, 2'd0, 9'd0,   0, 9,    1'b0, 1'b0, 9'd0,   4};
        tbl[1] = '{1'b0, 9'd0,   10'd0,   15'h0000, 1'b0, 1'b0, 2'd0, 9'd0,   0, 1,    1'b0, 1'b0, 9'd0,   0};
        tbl[2] = '{1'b0, 9'd37,  10'd5,   15'h7ab0, 1'b0, 1'b1, 2'd0, 9'd0,   0, 11,   1'b0, 1'b0, 9'd0,   5};
        tbl[3] = '{1'b1, 9'd508, 10'd8,   15'h0000, 1'b0, 1'b0, 2'd0, 9'd0,   0, 25,   1'b0, 1'b0, 9'd0,   8};
        tbl[4] = '{1'b1, 9'h120, 10'd16,  15'h0000, 1'b0, 1'b0, 2'd1, 9'h123, 0, 13,   1'b1, 1'b0, 9'h123, 4};
        tbl[5] = '{1'b1, 9'd100, 10'd16,  15'h0000, 1'b1, 1'b0, 2'd0, 9'd0,   0, -1,   1'b0, 1'b0, 9'd0,   16};
        tbl[6] = '{1'b1, 9'd0,   10'd8,   15'h0000, 1'b0, 1'b0, 2'd2, 9'd5,   0, 19,   1'b1, 1'b1, 9'd5,   6};
        tbl[7] = '{1'b0, 9'd0,   10'd0,   15'h0000, 1'b0, 1'b0, 2'd0, 9'd0,   0, 1,    1'b0, 1'b0, 9'd0,   0};
        tbl[8] = '{1'b1, 9'd200, 10'd4,   15'h0000, 1'b0, 1'b0, 2'd3, 9'd202, 0, 10,   1'b1, 1'b1, 9'd202, 3};
        tbl[9] = '{1'b0, 9'd3,   10'd512, 15'h1234, 1'b0, 1'b0, 2'd0, 9'd0,   0, 1025, 1'b0, 1'b0, 9'd0,   512};

        repeat (3) @(negedge clk);
        check("reset_state",
              {wready, dramWe, dramOwn, busy, done, error, parErr, dramAddr, dramDin, errAddr}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {busy, wready, done, dramWe}, 0);

        for (int i = 0; i < 10; i++) run_cmd(tbl[i]);

        // Reset during the third write of an 8-word load, then a normal command.
        rv       = tbl[0];
        rv.base  = 9'd20;
        rv.cnt   = 10'd8;
        rv.dbase = 15'h0440;
        rv.rst_w = 3;
        run_cmd(rv);
        run_cmd(tbl[0]);

        // Abort in WAITD, with a beat offered in the same cycle.
        start = 1'b1; mode = 1'b0; baseAddr = 9'd50; count = 10'd4;
        @(negedge clk);
        start = 1'b0;
        check("abort_wready", wready, 1);
        abort = 1'b1; wvalid = 1'b1; wdata = 15'h0abc;
        @(negedge clk);
        check("abort_idle", {busy, wready, dramWe, done}, 0);
        abort = 1'b0; wvalid = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | done | dramWe | busy;
        end
        check("abort_no_done", seen, 0);
        $display("cmd abort: base=32 cnt=4 aborted in WAITD");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
